// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR block: addresses, bit positions,
// trap causes and the read-modify-write operation encoding.
package csr_pkg;

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MIP      = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;

   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;
   localparam int MTIE_BIT = 7;
   localparam int MEIE_BIT = 11;

   localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;
   localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;

   typedef enum logic [1:0] {
      CSR_RW = 2'b01,
      CSR_RS = 2'b10,
      CSR_RC = 2'b11
   } csr_op_e;

   // Encoding 2'b00 is not a CSR op; returning the old value keeps it harmless.
   function automatic logic [31:0] csr_apply_op(input logic [1:0]  op,
                                                input logic [31:0] old_val,
                                                input logic [31:0] wdata);
      case (op)
         CSR_RW:  return wdata;
         CSR_RS:  return old_val | wdata;
         CSR_RC:  return old_val & ~wdata;
         default: return old_val;
      endcase
   endfunction

endpackage

// File: rtl/csr_cycle_counter.sv
// Free-running 64-bit cycle counter whose halves can each be overwritten.
// A written half takes the new value instead of counting that cycle.
module csr_cycle_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_wr_lo,
   input  logic        i_wr_hi,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_lo,
   output logic [31:0] o_hi
);

   logic [31:0] r_lo;
   logic [31:0] r_hi;
   logic        w_carry;

   // Writing the low half replaces its increment, so it produces no carry either.
   assign w_carry = ~i_wr_lo & (&r_lo);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lo <= '0;
         r_hi <= '0;
      end else begin
         r_lo <= i_wr_lo ? i_wdata : r_lo + 32'd1;
         r_hi <= i_wr_hi ? i_wdata : r_hi + {31'b0, w_carry};
      end
   end

   assign o_lo = r_lo;
   assign o_hi = r_hi;

endmodule

// File: rtl/csr_reg_file.sv
// Machine-mode CSR register file: CSR read-modify-write, interrupt detection,
// trap entry and mret return with a combinational PC redirect.
module csr_reg_file
   import csr_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter int          HAS_MCYCLE  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        csr_rd,
   input  logic        csr_wr,
   input  logic        is_mret,
   input  logic        inst_valid,
   input  logic [2:0]  funct3,
   input  logic [11:0] csr_addr,
   input  logic [31:0] wdata,
   input  logic [31:0] pc,
   input  logic        timer_irq,
   input  logic        ext_irq,
   output logic [31:0] rdata,
   output logic        epc_taken,
   output logic [31:0] evec
);

   logic        r_mie_bit;
   logic        r_mpie;
   logic        r_mtie;
   logic        r_meie;
   logic [31:0] r_mtvec;
   logic [31:0] r_mscratch;
   logic [31:0] r_mepc;
   logic [31:0] r_mcause;
   logic        r_mtip;
   logic        r_meip;

   logic [31:0] w_cyc_lo;
   logic [31:0] w_cyc_hi;
   logic [31:0] w_csr_old;
   logic [31:0] w_csr_new;
   logic        w_csr_we;
   logic        w_ext_pend;
   logic        w_tmr_pend;
   logic        w_trap;
   logic        w_mret;
   logic [31:0] w_cause;
   logic [31:0] w_trap_vec;
   logic        w_has_cyc;
   logic        w_unused;

   assign w_has_cyc = (HAS_MCYCLE != 0);
   assign w_unused  = ^{funct3[2], pc[1:0]};

   // Pre-write view of every CSR; unimplemented addresses read as zero.
   always_comb begin
      w_csr_old = '0;
      case (csr_addr)
         ADDR_MSTATUS:  w_csr_old = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie_bit, 3'b0};
         ADDR_MIE:      w_csr_old = {20'b0, r_meie, 3'b0, r_mtie, 7'b0};
         ADDR_MTVEC:    w_csr_old = r_mtvec;
         ADDR_MSCRATCH: w_csr_old = r_mscratch;
         ADDR_MEPC:     w_csr_old = r_mepc;
         ADDR_MCAUSE:   w_csr_old = r_mcause;
         ADDR_MIP:      w_csr_old = {20'b0, r_meip, 3'b0, r_mtip, 7'b0};
         ADDR_MCYCLE:   w_csr_old = w_has_cyc ? w_cyc_lo : 32'b0;
         ADDR_MCYCLEH:  w_csr_old = w_has_cyc ? w_cyc_hi : 32'b0;
         default:       w_csr_old = '0;
      endcase
   end

   assign rdata     = csr_rd ? w_csr_old : 32'b0;
   assign w_csr_new = csr_apply_op(funct3[1:0], w_csr_old, wdata);

   assign w_ext_pend = r_meie & r_meip;
   assign w_tmr_pend = r_mtie & r_mtip;
   assign w_trap     = r_mie_bit & (w_ext_pend | w_tmr_pend) & inst_valid;
   assign w_mret     = is_mret & inst_valid & ~w_trap;
   assign w_csr_we   = csr_wr & ~w_trap & ~is_mret & (funct3[1:0] != 2'b00);
   assign w_cause    = w_ext_pend ? CAUSE_M_EXT : CAUSE_M_TIMER;
   assign w_trap_vec = (r_mtvec[1:0] == 2'b01)
                     ? {r_mtvec[31:2], 2'b00} + {26'b0, w_cause[3:0], 2'b00}
                     : {r_mtvec[31:2], 2'b00};

   always_comb begin
      epc_taken = 1'b0;
      evec      = '0;
      if (w_trap) begin
         epc_taken = 1'b1;
         evec      = w_trap_vec;
      end else if (w_mret) begin
         epc_taken = 1'b1;
         evec      = r_mepc;
      end
   end

   // Trap entry outranks mret, which outranks an ordinary CSR write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mie_bit  <= 1'b0;
         r_mpie     <= 1'b0;
         r_mtie     <= 1'b0;
         r_meie     <= 1'b0;
         r_mtvec    <= MTVEC_RESET;
         r_mscratch <= '0;
         r_mepc     <= '0;
         r_mcause   <= '0;
         r_mtip     <= 1'b0;
         r_meip     <= 1'b0;
      end else begin
         r_mtip <= timer_irq;
         r_meip <= ext_irq;
         if (w_trap) begin
            r_mepc    <= {pc[31:2], 2'b00};
            r_mcause  <= w_cause;
            r_mpie    <= r_mie_bit;
            r_mie_bit <= 1'b0;
         end else if (w_mret) begin
            r_mie_bit <= r_mpie;
            r_mpie    <= 1'b1;
         end else if (w_csr_we) begin
            case (csr_addr)
               ADDR_MSTATUS: begin
                  r_mie_bit <= w_csr_new[MIE_BIT];
                  r_mpie    <= w_csr_new[MPIE_BIT];
               end
               ADDR_MIE: begin
                  r_mtie <= w_csr_new[MTIE_BIT];
                  r_meie <= w_csr_new[MEIE_BIT];
               end
               ADDR_MTVEC:    r_mtvec    <= {w_csr_new[31:2], 1'b0, (w_csr_new[1:0] == 2'b01)};
               ADDR_MSCRATCH: r_mscratch <= w_csr_new;
               ADDR_MEPC:     r_mepc     <= {w_csr_new[31:2], 2'b00};
               ADDR_MCAUSE:   r_mcause   <= w_csr_new;
               default: ;
            endcase
         end
      end
   end

   csr_cycle_counter u_cycle (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr_lo (w_csr_we & w_has_cyc & (csr_addr == ADDR_MCYCLE)),
      .i_wr_hi (w_csr_we & w_has_cyc & (csr_addr == ADDR_MCYCLEH)),
      .i_wdata (w_csr_new),
      .o_lo    (w_cyc_lo),
      .o_hi    (w_cyc_hi)
   );

endmodule

// File: tb/tb_csr_reg_file.sv
// Scoreboard bench for csr_reg_file: a driver predicts each cycle's outputs from
// an abstract CSR model and queues them; a monitor compares what the DUT shows.
module tb_csr_reg_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        csr_rd, csr_wr, is_mret, inst_valid;
   logic [2:0]  funct3;
   logic [11:0] csr_addr;
   logic [31:0] wdata, pc;
   logic        timer_irq, ext_irq;
   logic [31:0] rdata;
   logic        epc_taken;
   logic [31:0] evec;

   typedef struct packed {
      logic [31:0] rdata;
      logic        epc;
      logic [31:0] evec;
   } exp_t;

   exp_t expQ[$];
   int   errors = 0;
   int   checks = 0;
   event sampleEv;

   // Abstract machine state: only architecturally writable bits are kept.
   logic [31:0] mStatus, mIe, mTvec, mScratch, mEpc, mCause, mIp;
   logic [63:0] mCycle;

   csr_reg_file #(.MTVEC_RESET(32'h0), .HAS_MCYCLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .csr_rd(csr_rd), .csr_wr(csr_wr),
      .is_mret(is_mret), .inst_valid(inst_valid), .funct3(funct3),
      .csr_addr(csr_addr), .wdata(wdata), .pc(pc), .timer_irq(timer_irq),
      .ext_irq(ext_irq), .rdata(rdata), .epc_taken(epc_taken), .evec(evec)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      mStatus = 0; mIe = 0; mTvec = 0; mScratch = 0;
      mEpc = 0; mCause = 0; mIp = 0; mCycle = 0;
   endtask

   function automatic logic [31:0] modelRead(input logic [11:0] a);
      case (a)
         12'h300: return mStatus | 32'h1800;
         12'h304: return mIe;
         12'h305: return mTvec;
         12'h340: return mScratch;
         12'h341: return mEpc;
         12'h342: return mCause;
         12'h344: return mIp;
         12'hB00: return mCycle[31:0];
         12'hB80: return mCycle[63:32];
         default: return 32'h0;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
      end
   endtask

   // Drive one instruction cycle, queue its predicted outputs, then advance the model.
   task automatic applyStimulus(input logic rd, input logic wr, input logic mret, input logic valid,
                                input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd,
                                input logic [31:0] pcv, input logic tirq, input logic eirq);
      logic [31:0] old, nw, cause, base;
      logic        extP, tmrP, trap, doMret, doWr;
      exp_t        e;
      csr_rd = rd; csr_wr = wr; is_mret = mret; inst_valid = valid; funct3 = f3;
      csr_addr = a; wdata = wd; pc = pcv; timer_irq = tirq; ext_irq = eirq;
      old    = modelRead(a);
      extP   = mIe[11] && mIp[11];
      tmrP   = mIe[7] && mIp[7];
      trap   = mStatus[3] && (extP || tmrP) && valid;
      doMret = mret && valid && !trap;
      doWr   = wr && !trap && !mret && (f3[1:0] != 2'b00);
      cause  = extP ? 32'h8000_000B : 32'h8000_0007;
      base   = mTvec & ~32'h3;
      e.rdata = rd ? old : 32'h0;
      e.epc   = trap || doMret;
      e.evec  = trap ? ((mTvec[1:0] == 2'b01) ? base + 4 * cause[3:0] : base)
                     : (doMret ? mEpc : 32'h0);
      expQ.push_back(e);
      -> sampleEv;
      case (f3[1:0])
         2'b01:   nw = wd;
         2'b10:   nw = old | wd;
         2'b11:   nw = old & ~wd;
         default: nw = old;
      endcase
      @(posedge clk);
      if (!rst_n) begin
         modelReset();
      end else begin
         if (trap) begin
            mEpc    = pcv & ~32'h3;
            mCause  = cause;
            mStatus = mStatus[3] ? 32'h80 : 32'h0;
         end else if (doMret) begin
            mStatus = 32'h80 | (mStatus[7] ? 32'h8 : 32'h0);
         end else if (doWr) begin
            case (a)
               12'h300: mStatus  = nw & 32'h88;
               12'h304: mIe      = nw & 32'h880;
               12'h305: mTvec    = (nw & ~32'h3) | ((nw[1:0] == 2'b01) ? 32'h1 : 32'h0);
               12'h340: mScratch = nw;
               12'h341: mEpc     = nw & ~32'h3;
               12'h342: mCause   = nw;
               default: ;
            endcase
         end
         if (doWr && a == 12'hB00)      mCycle[31:0] = nw;
         else if (doWr && a == 12'hB80) mCycle = {nw, mCycle[31:0] + 32'd1};
         else                           mCycle = mCycle + 64'd1;
         mIp = (tirq ? 32'h80 : 32'h0) | (eirq ? 32'h800 : 32'h0);
      end
      @(negedge clk);
   endtask

   task automatic doCsr(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [11:0] a, input logic [31:0] wd);
      applyStimulus(rd, wr, 1'b0, 1'b1, f3, a, wd, 32'h1000, 1'b0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(sampleEv);
         #1;
         if (expQ.size() == 0) begin
            checkOutput("queue_underflow", 32'd0, 32'd1);
         end else begin
            e = expQ.pop_front();
            checkOutput("rdata", rdata, e.rdata);
            checkOutput("epc_taken", {31'b0, epc_taken}, {31'b0, e.epc});
            checkOutput("evec", evec, e.evec);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : driver
      logic [11:0] addrs [10];
      logic [11:0] a;
      logic        wr, mr;
      addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                12'h342, 12'h344, 12'hB00, 12'hB80, 12'h7C0};
      modelReset();
      rst_n = 1'b0; csr_rd = 0; csr_wr = 0; is_mret = 0; inst_valid = 0;
      funct3 = 0; csr_addr = 0; wdata = 0; pc = 0; timer_irq = 0; ext_irq = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      $display("[TB] reset released");

      doCsr(0, 0, 3'b001, 12'h000, 32'h0);
      doCsr(1, 0, 3'b001, 12'h300, 32'h0);
      // Scratch read-modify-write sequence
      doCsr(1, 1, 3'b001, 12'h340, 32'hDEADBEEF);
      doCsr(1, 1, 3'b010, 12'h340, 32'h10);
      doCsr(1, 0, 3'b010, 12'h340, 32'h0);
      // mstatus set then clear of MIE
      doCsr(1, 1, 3'b001, 12'h300, 32'h88);
      doCsr(1, 1, 3'b011, 12'h300, 32'h8);
      doCsr(1, 0, 3'b011, 12'h300, 32'h0);
      // Direct-mode timer trap
      doCsr(0, 1, 3'b001, 12'h305, 32'h100);
      doCsr(0, 1, 3'b001, 12'h304, 32'h80);
      doCsr(0, 1, 3'b110, 12'h300, 32'h8);
      applyStimulus(0, 0, 0, 1, 3'b000, 12'h0, 32'h0, 32'h2004, 1'b1, 1'b0);
      applyStimulus(0, 0, 0, 1, 3'b000, 12'h0, 32'h0, 32'h2004, 1'b0, 1'b0);
      doCsr(1, 0, 3'b010, 12'h341, 32'h0);
      doCsr(1, 0, 3'b010, 12'h342, 32'h0);
      doCsr(1, 0, 3'b010, 12'h300, 32'h0);
      // Vectored mode, both interrupts, concurrent scratch write suppressed
      doCsr(0, 1, 3'b001, 12'h305, 32'h101);
      doCsr(0, 1, 3'b010, 12'h304, 32'h800);
      doCsr(0, 1, 3'b010, 12'h300, 32'h8);
      applyStimulus(0, 0, 0, 1, 3'b000, 12'h0, 32'h0, 32'h3008, 1'b1, 1'b1);
      applyStimulus(1, 1, 0, 1, 3'b001, 12'h340, 32'h1234, 32'h300A, 1'b0, 1'b0);
      doCsr(1, 0, 3'b010, 12'h342, 32'h0);
      doCsr(1, 0, 3'b010, 12'h340, 32'h0);
      // mret back to the saved PC
      applyStimulus(0, 0, 1, 1, 3'b000, 12'h0, 32'h0, 32'h4000, 1'b0, 1'b0);
      doCsr(1, 0, 3'b010, 12'h300, 32'h0);
      // Cycle counter wrap across the halves
      doCsr(0, 1, 3'b001, 12'hB00, 32'hFFFFFFFF);
      doCsr(0, 1, 3'b001, 12'hB80, 32'h0);
      doCsr(0, 0, 3'b001, 12'h0, 32'h0);
      doCsr(1, 0, 3'b010, 12'hB00, 32'h0);
      doCsr(1, 0, 3'b010, 12'hB80, 32'h0);
      doCsr(1, 1, 3'b001, 12'h7C0, 32'hFFFF);
      doCsr(1, 0, 3'b010, 12'h7C0, 32'h0);

      // Asynchronous reset in the middle of activity
      doCsr(0, 1, 3'b001, 12'h340, 32'hCAFEF00D);
      #2 rst_n = 1'b0;
      #1 modelReset();
      @(negedge clk);
      doCsr(1, 0, 3'b010, 12'h340, 32'h0);
      doCsr(1, 0, 3'b010, 12'h305, 32'h0);
      rst_n = 1'b1;
      doCsr(1, 0, 3'b010, 12'hB00, 32'h0);

      for (int i = 0; i < 400; i++) begin
         a  = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(0, 4095)) : addrs[$urandom_range(0, 9)];
         mr = ($urandom_range(0, 9) == 0);
         wr = mr ? 1'b0 : $urandom_range(0, 1) == 1;
         applyStimulus($urandom_range(0, 3) != 0, wr, mr, $urandom_range(0, 7) != 0,
                       3'($urandom_range(4, 0) | ($urandom_range(1, 3))),
                       a, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15) << 2) | 32'h88 : $urandom,
                       $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      end

      @(negedge clk);
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
